// File: rtl/dtree_pkg.sv
// Shared definitions for the decision-tree front end.
// DEFAULT_CHANNELS : default channel count for the scheduler/decoder pair
// DEFAULT_LOG      : width of an encoded channel index at the default count
// chan_idx_t       : encoded channel index, as seen on the decoder input
// wrap_add         : (a + b) mod n for operands already below n
package dtree_pkg;

  localparam int unsigned DEFAULT_CHANNELS = 16;
  localparam int unsigned DEFAULT_LOG      = $clog2(DEFAULT_CHANNELS);

  typedef logic [DEFAULT_LOG-1:0] chan_idx_t;

  function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                           input int unsigned n);
    int unsigned s;
    s = a + b;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: first set bit of pending at or above ptr,
// wrapping from CHANNELS-1 back to 0.
// pending : request vector to search
// ptr     : search start position (always < CHANNELS)
// found   : at least one pending bit set
// index   : encoded position of the selected bit (0 when nothing found)
module rr_priority_select
  import dtree_pkg::*;
#(
  parameter int unsigned CHANNELS = DEFAULT_CHANNELS,
  localparam int unsigned LOG_CHANNELS = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0]     pending,
  input  logic [LOG_CHANNELS-1:0] ptr,
  output logic                    found,
  output logic [LOG_CHANNELS-1:0] index
);

  logic [CHANNELS-1:0] rotated;
  int unsigned         offset;

  // Rotate so that position ptr lands at bit 0; modulo arithmetic keeps
  // non-power-of-two channel counts correct.
  always_comb begin
    rotated = '0;
    for (int unsigned j = 0; j < CHANNELS; j++) begin
      rotated[j] = pending[wrap_add(j, 32'(ptr), CHANNELS)];
    end
  end

  // Lowest-set-bit encoder on the rotated vector.
  always_comb begin
    found  = 1'b0;
    offset = 0;
    for (int unsigned j = 0; j < CHANNELS; j++) begin
      if (!found && rotated[j]) begin
        found  = 1'b1;
        offset = j;
      end
    end
  end

  // Un-rotate back to an absolute channel number.
  always_comb begin
    index = '0;
    if (found) index = LOG_CHANNELS'(wrap_add(offset, 32'(ptr), CHANNELS));
  end

endmodule

// File: rtl/channel_scheduler.sv
// Round-robin scheduler feeding encoded channel indices to the shared
// decision-tree engine through a valid/ready handshake.
// clk, rst_n     : clock (rising edge), asynchronous active-low reset
// req            : per-channel one-cycle "sample ready" pulses
// out_valid      : out_channel holds a granted channel
// out_ready      : engine accepts the current channel this cycle
// out_channel    : encoded index of the granted channel
// pending        : registered pending-request vector
// overrun        : sticky per-channel lost-sample flags
// overrun_clear  : synchronous clear of all overrun flags (wins over a set)
module channel_scheduler
  import dtree_pkg::*;
#(
  parameter int unsigned CHANNELS = DEFAULT_CHANNELS,
  localparam int unsigned LOG_CHANNELS = $clog2(CHANNELS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CHANNELS-1:0]     req,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LOG_CHANNELS-1:0] out_channel,
  output logic [CHANNELS-1:0]     pending,
  output logic [CHANNELS-1:0]     overrun,
  input  logic                    overrun_clear
);

  logic [LOG_CHANNELS-1:0] ptr;
  logic                    sel_found;
  logic [LOG_CHANNELS-1:0] sel_index;
  logic                    load;
  logic                    grant;
  logic [CHANNELS-1:0]     load_vec;
  logic [LOG_CHANNELS-1:0] ptr_next;

  rr_priority_select #(.CHANNELS(CHANNELS)) u_select (
    .pending (pending),
    .ptr     (ptr),
    .found   (sel_found),
    .index   (sel_index)
  );

  // Output register is free when empty or being drained this edge.
  assign load  = !out_valid || out_ready;
  assign grant = load && sel_found;

  always_comb begin
    load_vec = '0;
    if (grant) load_vec[sel_index] = 1'b1;
  end

  assign ptr_next = (sel_index == LOG_CHANNELS'(CHANNELS - 1)) ? '0 : sel_index + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= '0;
      overrun     <= '0;
      out_valid   <= 1'b0;
      out_channel <= '0;
      ptr         <= '0;
    end else begin
      // A req on the edge its channel is loaded re-arms pending rather than
      // counting as a lost sample.
      pending <= (pending & ~load_vec) | req;
      if (overrun_clear) overrun <= '0;
      else               overrun <= overrun | (req & pending & ~load_vec);
      if (load) begin
        if (sel_found) begin
          out_valid   <= 1'b1;
          out_channel <= sel_index;
          ptr         <= ptr_next;
        end else begin
          out_valid   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_channel_scheduler.sv
module tb_channel_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_channel;
  logic [15:0] pending;
  logic [15:0] overrun;
  logic        overrun_clear;

  int checks   = 0;
  int failures = 0;

  channel_scheduler #(.CHANNELS(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_channel   (out_channel),
    .pending       (pending),
    .overrun       (overrun),
    .overrun_clear (overrun_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] req;
    logic        rdy;
    logic        clr;
    logic        ov;
    logic [3:0]  ch;
    logic [15:0] pend;
    logic [15:0] ovr;
  } vec_t;

  vec_t vecs [30];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ov, input logic [3:0] ch,
                         input logic [15:0] pend, input logic [15:0] ovr);
    chk({tag, " out_valid"},   32'(out_valid),   32'(ov));
    chk({tag, " out_channel"}, 32'(out_channel), 32'(ch));
    chk({tag, " pending"},     32'(pending),     32'(pend));
    chk({tag, " overrun"},     32'(overrun),     32'(ovr));
  endtask

  // Inputs change 1 time unit after a rising edge; results are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Each row: inputs for one edge, then the state expected after it.
    vecs[0]  = '{16'h0000, 1'b1, 1'b0, 1'b0, 4'd0,  16'h0000, 16'h0000};
    vecs[1]  = '{16'h0020, 1'b1, 1'b0, 1'b0, 4'd0,  16'h0020, 16'h0000}; // req5 captured
    vecs[2]  = '{16'h0000, 1'b1, 1'b0, 1'b1, 4'd5,  16'h0000, 16'h0000}; // grant 5, ptr=6
    vecs[3]  = '{16'h0000, 1'b1, 1'b0, 1'b0, 4'd5,  16'h0000, 16'h0000}; // drop, channel held
    vecs[4]  = '{16'h2000, 1'b1, 1'b0, 1'b0, 4'd5,  16'h2000, 16'h0000};
    vecs[5]  = '{16'h0000, 1'b1, 1'b0, 1'b1, 4'd13, 16'h0000, 16'h0000}; // ptr=14
    vecs[6]  = '{16'hC004, 1'b1, 1'b0, 1'b0, 4'd13, 16'hC004, 16'h0000}; // 2,14,15
    vecs[7]  = '{16'h0000, 1'b1, 1'b0, 1'b1, 4'd14, 16'h8004, 16'h0000};
    vecs[8]  = '{16'h0000, 1'b1, 1'b0, 1'b1, 4'd15, 16'h0004, 16'h0000};
    vecs[9]  = '{16'h0000, 1'b1, 1'b0, 1'b1, 4'd2,  16'h0000, 16'h0000}; // wrap
    vecs[10] = '{16'h0000, 1'b1, 1'b0, 1'b0, 4'd2,  16'h0000, 16'h0000};
    vecs[11] = '{16'h0008, 1'b1, 1'b0, 1'b0, 4'd2,  16'h0008, 16'h0000};
    vecs[12] = '{16'h0000, 1'b0, 1'b0, 1'b1, 4'd3,  16'h0000, 16'h0000}; // empty reg loads
    vecs[13] = '{16'h0080, 1'b0, 1'b0, 1'b1, 4'd3,  16'h0080, 16'h0000}; // stalled
    vecs[14] = '{16'h0000, 1'b0, 1'b0, 1'b1, 4'd3,  16'h0080, 16'h0000};
    vecs[15] = '{16'h0000, 1'b0, 1'b0, 1'b1, 4'd3,  16'h0080, 16'h0000};
    vecs[16] = '{16'h0000, 1'b0, 1'b0, 1'b1, 4'd3,  16'h0080, 16'h0000};
    vecs[17] = '{16'h0000, 1'b1, 1'b0, 1'b1, 4'd7,  16'h0000, 16'h0000}; // back-to-back
    vecs[18] = '{16'h0000, 1'b1, 1'b0, 1'b0, 4'd7,  16'h0000, 16'h0000};
    vecs[19] = '{16'h0010, 1'b1, 1'b0, 1'b0, 4'd7,  16'h0010, 16'h0000};
    vecs[20] = '{16'h0000, 1'b0, 1'b0, 1'b1, 4'd4,  16'h0000, 16'h0000}; // ptr=5
    vecs[21] = '{16'h0010, 1'b0, 1'b0, 1'b1, 4'd4,  16'h0010, 16'h0000}; // req for held ch
    vecs[22] = '{16'h0010, 1'b0, 1'b0, 1'b1, 4'd4,  16'h0010, 16'h0010}; // overrun
    vecs[23] = '{16'h0000, 1'b0, 1'b0, 1'b1, 4'd4,  16'h0010, 16'h0010}; // sticky
    vecs[24] = '{16'h0010, 1'b0, 1'b1, 1'b1, 4'd4,  16'h0010, 16'h0000}; // clear beats set
    vecs[25] = '{16'h0010, 1'b0, 1'b0, 1'b1, 4'd4,  16'h0010, 16'h0010};
    vecs[26] = '{16'h0000, 1'b0, 1'b1, 1'b1, 4'd4,  16'h0010, 16'h0000};
    vecs[27] = '{16'h0010, 1'b1, 1'b0, 1'b1, 4'd4,  16'h0010, 16'h0000}; // req on load edge
    vecs[28] = '{16'h0000, 1'b1, 1'b0, 1'b1, 4'd4,  16'h0000, 16'h0000};
    vecs[29] = '{16'h0000, 1'b1, 1'b0, 1'b0, 4'd4,  16'h0000, 16'h0000};

    rst_n = 1'b0; req = '0; out_ready = 1'b0; overrun_clear = 1'b0;
    #12 rst_n = 1'b1;
    #1;
    chk_all("reset", 1'b0, 4'd0, 16'h0000, 16'h0000);

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      step();
      chk_all($sformatf("idle%0d", i), 1'b0, 4'd0, 16'h0000, 16'h0000);
    end

    // Directed table
    for (int i = 0; i < 30; i++) begin
      req = vecs[i].req; out_ready = vecs[i].rdy; overrun_clear = vecs[i].clr;
      step();
      chk_all($sformatf("v%0d", i), vecs[i].ov, vecs[i].ch, vecs[i].pend, vecs[i].ovr);
    end

    // Fairness: every channel requesting every cycle, ptr starts at 5
    req = 16'hFFFF; out_ready = 1'b1; overrun_clear = 1'b1;
    step();
    chk("fair_first out_valid", 32'(out_valid), 32'd0);
    chk("fair_first pending", 32'(pending), 32'hFFFF);
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("fair%0d out_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("fair%0d out_channel", k), 32'(out_channel), 32'((5 + k) % 16));
    end

    // Async reset mid-handshake
    req = '0; out_ready = 1'b0; overrun_clear = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all("rst_clear", 1'b0, 4'd0, 16'h0000, 16'h0000);
    rst_n = 1'b1;
    req = 16'h00F0;
    step();
    chk_all("pre_rst0", 1'b0, 4'd0, 16'h00F0, 16'h0000);
    step();
    chk_all("pre_rst1", 1'b1, 4'd4, 16'h00F0, 16'h00E0);
    req = '0;
    #1 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 4'd0, 16'h0000, 16'h0000);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_all($sformatf("post_rst%0d", i), 1'b0, 4'd0, 16'h0000, 16'h0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/channel_scheduler.md
Name: channel_scheduler

Overview:
- Round-robin scheduler directly upstream of the channel decoder.
- Per-channel sample-ready pulses from the front-end are captured as pending requests. One channel at a time is handed to the shared decision-tree engine as an encoded index with a valid/ready handshake.
- The out_channel bus feeds the decoder's encoded input. The decoder's one-hot output then selects the channel's feature/result registers.

Parameters:
- CHANNELS, 16, number of input channels; legal range 2..256; need not be a power of two.
- LOG_CHANNELS, $clog2(CHANNELS), derived localparam; width of the encoded index (matches decoder input width).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  CHANNELS  one-cycle pulse per channel: new sample ready.
- out_valid  output  1  out_channel holds a granted channel.
- out_ready  input  1  tree engine accepts the current channel this cycle.
- out_channel  output  LOG_CHANNELS  encoded index of granted channel, to the decoder.
- pending  output  CHANNELS  registered pending-request vector (status).
- overrun  output  CHANNELS  sticky per-channel lost-sample flags.
- overrun_clear  input  1  synchronous clear of all overrun bits.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pending, overrun, out_valid, out_channel and the round-robin pointer ptr all go to 0.
  - Reset mid-handshake discards the in-flight grant; no state survives.
- Pending capture: at each edge, pending[i] <= (pending[i] & ~load_i) | req[i].
  - load_i means channel i is being loaded into the output register this edge.
- Output register:
  - Loads when (!out_valid || out_ready).
  - When it loads and any pending bit is set, it takes the first set bit found searching upward from ptr with wrap at CHANNELS-1 -> 0. Then out_valid <= 1, out_channel <= index, pending[index] cleared, ptr <= index+1 (wraps to 0 after CHANNELS-1).
  - When it loads with no pending bit set: out_valid <= 0; out_channel holds its last value; ptr unchanged.
- Handshake:
  - While out_valid && !out_ready, out_channel and out_valid are held stable.
  - Transfer occurs on the edge where out_valid && out_ready; the next channel may load on that same edge (back-to-back, one grant per cycle).
- Selection uses pending as registered. A req arriving this edge is not eligible until the next edge.
- Latency: req pulse sampled at edge E0 -> pending set after E0 -> out_valid high after E1 (if the output register is free).
- Overrun:
  - Set overrun[i] when req[i] && pending[i] && !load_i at an edge.
  - req[i] on the same edge that channel i is loaded is not an overrun; pending[i] ends set.
  - A req for the channel currently in the output register is not an overrun.
  - overrun_clear has priority over a simultaneous set: the bit ends 0, and the event is lost.
- Fairness: with all channels continuously pending and out_ready=1, grants cycle 0,1,...,CHANNELS-1,0,...
- No combinational path from req or out_ready to any output; all outputs are registered.

Decomposition:
- Shared package dtree_pkg: CHANNELS default constant and LOG_CHANNELS; the channel-index typedef sized LOG_CHANNELS, also used by the decoder instance.
- One sub-module: rr_priority_select, combinational. Inputs are the pending vector and ptr. Outputs are found and index, computed by rotate, priority-encode, then un-rotate.

Test Plan:
- Reset/idle: rst_n low then high, no req -> out_valid=0, pending=0, overrun=0, out_channel=0 for 20 cycles.
- Single request: req[5] pulse at E0, out_ready=1 -> out_valid=1 with out_channel=5 after E1. out_valid drops next cycle. ptr=6.
- Round-robin wrap (CHANNELS=16): ptr=14, req on channels 2, 14 and 15 in the same cycle -> grants 14, 15, 2 on consecutive cycles.
- Backpressure: out_channel=3 valid, out_ready=0 for 5 cycles while req[7] arrives -> out_channel stays 3. After out_ready=1, 7 is granted on the next edge.
- Overrun: req[4] twice while pending[4] set and output stalled -> overrun[4]=1. A same-edge overrun_clear and new overrun leaves overrun[4]=0. Sticky otherwise.
- Async reset mid-handshake: out_valid=1, pending=16'h00F0, rst_n pulsed low between edges -> all outputs 0 immediately, without waiting for a clock edge. After release, no grant is issued.
